// File: rtl/backprop_sequencer.sv
// Control sequencer for one backprop_stack: clears the stack, loads it, then walks layers
// last-to-first issuing dy/dy_old and handing each dc_dw index downstream. Optional macro BACKPROP_SEQ_PERF_EN.
module backprop_sequencer #(
    parameter int max_layer_size = 4,
    parameter int index_width    = 33,
    parameter int count_width    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [count_width-1:0] num_layers,
    input  logic                   abort,
    input  logic                   dc_dw_ready,
    output logic                   stack_clr,
    output logic                   copy,
    output logic                   cal_dy_dy_old,
    output logic [index_width-1:0] current_layer_index,
    output logic [index_width-1:0] dc_dw_layer_index,
    output logic                   dc_dw_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   err
`ifdef BACKPROP_SEQ_PERF_EN
    ,
    output logic [15:0]            stall_cycles
`endif
);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, CALC, EMIT, DONE} state_t;

    state_t                 state, state_next;
    logic [count_width-1:0] layer, layer_next;
    logic                   legal;
    logic                   err_next;

    function automatic logic [index_width-1:0] zext(input logic [count_width-1:0] v);
        return index_width'(v);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_next = state;
        layer_next = layer;
        err_next   = 1'b0;
        legal      = (num_layers != '0) && (num_layers <= count_width'(max_layer_size));
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (legal) begin
                        state_next = CLEAR;
                        layer_next = num_layers - count_width'(1);
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            CLEAR: state_next = LOAD;
            LOAD:  state_next = CALC;
            CALC:  state_next = EMIT;
            EMIT: begin
                if (dc_dw_ready) begin
                    if (layer == '0) begin
                        state_next = DONE;
                    end else begin
                        layer_next = layer - count_width'(1);
                        state_next = CALC;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // abort outranks everything outside IDLE, including a same-cycle handshake
        if (abort && state != IDLE) begin
            state_next = IDLE;
            layer_next = layer;
        end
    end

    // Outputs are registered decodes of the next state, so they line up with the state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            layer               <= '0;
            stack_clr           <= 1'b0;
            copy                <= 1'b0;
            cal_dy_dy_old       <= 1'b0;
            dc_dw_valid         <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            err                 <= 1'b0;
            current_layer_index <= '0;
            dc_dw_layer_index   <= '0;
        end else begin
            state         <= state_next;
            layer         <= layer_next;
            stack_clr     <= (state_next == CLEAR);
            copy          <= (state_next == LOAD);
            cal_dy_dy_old <= (state_next == CALC);
            dc_dw_valid   <= (state_next == EMIT);
            busy          <= (state_next != IDLE);
            done          <= (state_next == DONE);
            err           <= err_next;
            if (state_next == LOAD || state_next == CALC)
                current_layer_index <= zext(layer_next);
            if (state_next == EMIT)
                dc_dw_layer_index <= zext(layer_next);
        end
    end

`ifdef BACKPROP_SEQ_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles <= '0;
        end else if (state == IDLE && state_next == CLEAR) begin
            stall_cycles <= '0;
        end else if (state == EMIT && !dc_dw_ready) begin
            stall_cycles <= sat_inc(stall_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_backprop_sequencer.sv
// Randomized bench for backprop_sequencer against a work-list model of a backprop run.
// Build with BACKPROP_SEQ_PERF_EN defined to also check stall_cycles.
module tb_backprop_sequencer;

    localparam int MAXL = 4;
    localparam int K_CLR = 0, K_LOAD = 1, K_CAL = 2, K_EMIT = 3, K_DONE = 4;

    typedef struct {
        int kind;
        int layer;
    } work_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  num_layers;
    logic        abort;
    logic        dc_dw_ready;
    logic        stack_clr, copy, cal_dy_dy_old, dc_dw_valid, busy, done, err;
    logic [32:0] current_layer_index, dc_dw_layer_index;
`ifdef BACKPROP_SEQ_PERF_EN
    logic [15:0] stall_cycles;
`endif

    backprop_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .num_layers(num_layers),
        .abort(abort), .dc_dw_ready(dc_dw_ready), .stack_clr(stack_clr), .copy(copy),
        .cal_dy_dy_old(cal_dy_dy_old), .current_layer_index(current_layer_index),
        .dc_dw_layer_index(dc_dw_layer_index), .dc_dw_valid(dc_dw_valid), .busy(busy),
        .done(done), .err(err)
`ifdef BACKPROP_SEQ_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int    vectors = 0;
    int    miscompares = 0;
    work_t wq[$];
    int    m_cur, m_dcdw, m_stall;
    bit    m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int front_kind();
        return (wq.size() > 0) ? wq[0].kind : -1;
    endfunction

    task automatic model_reset();
        wq.delete();
        m_cur = 0; m_dcdw = 0; m_stall = 0; m_err = 0;
    endtask

    // One clock of the reference: the queue front is the operation visible this cycle
    task automatic model_step();
        m_err = 0;
        if (wq.size() > 0) begin
            if (wq[0].kind == K_EMIT && !dc_dw_ready && m_stall != 65535) m_stall++;
            if (abort) wq.delete();
            else if (wq[0].kind != K_EMIT || dc_dw_ready) void'(wq.pop_front());
        end else if (start && !abort) begin
            if (num_layers >= 1 && num_layers <= MAXL) begin
                wq.push_back('{K_CLR, 0});
                wq.push_back('{K_LOAD, int'(num_layers) - 1});
                for (int l = int'(num_layers) - 1; l >= 0; l--) begin
                    wq.push_back('{K_CAL, l});
                    wq.push_back('{K_EMIT, l});
                end
                wq.push_back('{K_DONE, 0});
                m_stall = 0;
            end else begin
                m_err = 1;
            end
        end
        if (wq.size() > 0) begin
            if (wq[0].kind == K_LOAD || wq[0].kind == K_CAL) m_cur = wq[0].layer;
            if (wq[0].kind == K_EMIT) m_dcdw = wq[0].layer;
        end
    endtask

    task automatic compare_all();
        chk("stack_clr", stack_clr, front_kind() == K_CLR);
        chk("copy", copy, front_kind() == K_LOAD);
        chk("cal_dy_dy_old", cal_dy_dy_old, front_kind() == K_CAL);
        chk("dc_dw_valid", dc_dw_valid, front_kind() == K_EMIT);
        chk("done", done, front_kind() == K_DONE);
        chk("busy", busy, wq.size() > 0);
        chk("err", err, m_err);
        chk("current_layer_index", current_layer_index, m_cur);
        chk("dc_dw_layer_index", dc_dw_layer_index, m_dcdw);
`ifdef BACKPROP_SEQ_PERF_EN
        chk("stall_cycles", stall_cycles, m_stall);
`endif
    endtask

    task automatic cycle(input logic s, input logic [7:0] n, input logic ab, input logic rdy);
        start = s; num_layers = n; abort = ab; dc_dw_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    // Called just after a compare (posedge+1); reset lands and releases between edges
    task automatic async_reset();
        #3 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        #2 reset = 1'b1;
    endtask

    int lat_done, lat_valid, cnt;

    initial begin
        reset = 1'b0; start = 0; num_layers = 0; abort = 0; dc_dw_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 compare_all();
        #2 reset = 1'b1;

        // basic run, N=3, ready high
        lat_done = 0; lat_valid = 0;
        cycle(1, 3, 0, 1);
        for (int i = 2; i <= 20; i++) begin
            cycle(0, 0, 0, 1);
            if (dc_dw_valid && lat_valid == 0) lat_valid = i;
            if (done && lat_done == 0) lat_done = i;
        end
        chk("first_valid_latency", lat_valid, 4);
        chk("done_latency_n3", lat_done, 9);

        // backpressure: five stalled cycles in the first EMIT
        cycle(1, 2, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0);
        repeat (8) cycle(0, 0, 0, 1);
`ifdef BACKPROP_SEQ_PERF_EN
        chk("stall_total", stall_cycles, 5);
`endif

        // illegal counts
        cnt = 0;
        cycle(1, 0, 0, 1); cnt += err;
        cycle(0, 0, 0, 1); cnt += err;
        cycle(1, 5, 0, 1); cnt += err;
        cycle(0, 0, 0, 1); cnt += err;
        chk("err_pulses", cnt, 2);

        // abort in the second CALC, then a clean N=1 run
        cycle(1, 4, 0, 1);
        repeat (4) cycle(0, 0, 0, 1);
        cnt = 0;
        cycle(0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin cycle(0, 0, 0, 1); cnt += done; end
        chk("done_after_abort", cnt, 0);
        lat_done = 0;
        cycle(1, 1, 0, 1);
        for (int i = 2; i <= 10; i++) begin
            cycle(0, 0, 0, 1);
            if (done && lat_done == 0) lat_done = i;
        end
        chk("done_latency_n1", lat_done, 5);

        // start while busy is ignored
        cnt = 0;
        cycle(1, 2, 0, 0); cnt += done;
        for (int i = 0; i < 6; i++) begin cycle(1, 3, 0, 0); cnt += done; end
        for (int i = 0; i < 10; i++) begin cycle(0, 0, 0, 1); cnt += done; end
        chk("single_done", cnt, 1);

        // asynchronous reset in the middle of EMIT
        cycle(1, 3, 0, 0);
        repeat (5) cycle(0, 0, 0, 0);
        async_reset();
        repeat (2) cycle(0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 900; i++) begin
            cycle(($urandom_range(0, 3) == 0), 8'($urandom_range(0, 6)),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0));
            if (i % 200 == 150) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
